l2_write_buffer: RTL and testbench
==================================

# l2_write_buffer

Write-back buffer between the L2 cache's memory-side port and the cacheline adaptor. It absorbs L2 dirty-line evictions into a small FIFO and acknowledges them after one cycle, so the L2 can refill without waiting for the write burst. It drains the FIFO to memory when no upstream request is pending. Reads that hit a buffered line are forwarded from the buffer; read misses go straight to memory ahead of queued writes.

## Interface
- DEPTH, 4, number of 256-bit line entries (≥1)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_address  in  32  L2-side line address; bits [4:0] ignored
- mem_read  in  1  L2 read request
- mem_write  in  1  L2 write request; never asserted together with mem_read
- mem_wdata  in  256  line to write
- mem_rdata  out  256  returned line, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  memory-side address; bits [4:0] always 0
- pmem_read  out  1  read request to the adaptor
- pmem_write  out  1  write request to the adaptor
- pmem_wdata  out  256  line to write
- pmem_rdata  in  256  line from the adaptor
- pmem_resp  in  1  adaptor completion pulse
- buf_empty  out  1  1 when the FIFO holds no entries

## Operation
- Storage:
  - DEPTH entries of {tag[31:5], data[255:0]}.
  - Circular head/tail pointers with an occupancy count from 0 to DEPTH.
  - Pointers wrap from DEPTH-1 to 0.
- Match: an entry matches when its tag equals mem_address[31:5]. At most one entry can match a given tag, because writes coalesce.
- States: IDLE, RESP, FETCH, DRAIN. All transitions happen on the rising edge of clk.
- IDLE, first applicable rule wins:
  1. mem_write and a matching entry: overwrite that entry's data in place (count unchanged). Go to RESP.
  2. mem_write, no match, count<DEPTH: enqueue at tail, count+1. Go to RESP.
  3. mem_write, no match, count==DEPTH: go to DRAIN. The write stays pending and is retried from IDLE.
  4. mem_read and a matching entry: latch the entry's data into mem_rdata. Go to RESP.
  5. mem_read, no match: latch {mem_address[31:5],5'b0} as the fetch address. Go to FETCH.
  6. No request and count>0: go to DRAIN.
  7. Otherwise stay in IDLE.
- FETCH:
  - Drive pmem_read=1 with the latched address.
  - On pmem_resp, latch pmem_rdata into mem_rdata and go to RESP.
- DRAIN:
  - Drive pmem_write=1, pmem_address={head.tag,5'b0} and pmem_wdata=head.data.
  - On pmem_resp, pop the head (count-1) and go to IDLE.
  - Upstream requests are not serviced in DRAIN; they wait.
- RESP: mem_resp=1 for exactly one cycle, then go to IDLE.
- The upstream requester holds its request and operands stable until mem_resp. The block samples the request only in IDLE.
- A read that misses the buffer is never serviced from a stale memory copy. A line being drained is still in the buffer until pmem_resp, and reads are not accepted during DRAIN.
- buf_empty = (count==0), a combinational decode of the registered count.

## Timing
- Reset (async):
  - State goes to IDLE, count=0, pointers=0, all entries are discarded.
  - mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address=0, pmem_wdata=0, buf_empty=1.
  - An in-flight pmem transaction is abandoned immediately. The outputs drop asynchronously.
- All outputs are registered or decoded from state. There is no combinational path from mem_* to pmem_*.
- Write enqueue or coalesce, and read buffer hit: request sampled at edge t in IDLE, mem_resp high during the cycle after edge t (1-cycle latency).
- Read miss: pmem_read high from the cycle after edge t until pmem_resp is sampled at edge u. mem_resp is high during the cycle after edge u.
- Drain: pmem_write is held with stable address and data until pmem_resp. The pop is visible in count the cycle after pmem_resp.
- Write to a full buffer: latency = one drain + 1 cycle.
- pmem_read and pmem_write are never high together.

## Test plan
- Basic write: after reset, write 0x0000_1040 with data A.
  - Required: mem_resp 1 cycle later, buf_empty=0.
  - With no further requests: pmem_write to 0x0000_1040 with data A, then buf_empty=1 after pmem_resp.
- Coalesce: with drain stalled (pmem_resp withheld so the buffer holds), write 0x2000 with data A, then 0x201C with data B.
  - Required: count=1.
  - The drain writes B to 0x2000 exactly once.
- Read forward and read miss:
  - Write 0x3000 with data C, then read 0x3004. Required: mem_rdata=C after 1 cycle, no pmem_read.
  - Read 0x4000. Required: pmem_read to 0x4000 before any pmem_write, and mem_rdata=pmem_rdata.
- Full buffer (DEPTH=4): write four distinct lines, then a fifth.
  - Required: no mem_resp for the fifth until one pmem_write completes.
  - Required: the drain order is FIFO (first line first) and count is 4 after the fifth is accepted.
- Reset mid-drain: assert rst while pmem_write=1 with 3 entries queued.
  - Required: pmem_write=0 immediately, buf_empty=1, and no later writes without new requests.

Source files
------------

// File: rtl/l2_write_buffer.sv
// l2_write_buffer
//   Write-back buffer sitting between the L2 memory-side port and the
//   cacheline adaptor. Dirty-line evictions are absorbed into a small FIFO
//   and acknowledged after one cycle. Writes to a line already queued are
//   coalesced in place. Reads that hit a queued line are forwarded from the
//   buffer. Read misses go to memory ahead of queued writes. The FIFO drains
//   whenever no upstream request is pending.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   mem_address     L2-side line address (bits [4:0] ignored)
//   mem_read        L2 read request
//   mem_write       L2 write request
//   mem_wdata       line to write
//   mem_rdata       returned line, valid while mem_resp=1
//   mem_resp        one-cycle completion pulse to the L2
//   pmem_address    memory-side line address (bits [4:0] always 0)
//   pmem_read       read request to the adaptor
//   pmem_write      write request to the adaptor
//   pmem_wdata      line written to the adaptor
//   pmem_rdata      line returned by the adaptor
//   pmem_resp       adaptor completion pulse
//   buf_empty       1 when the FIFO holds no entries
module l2_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         buf_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RESP, FETCH, DRAIN} state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   hit_idx;
    logic [CNT_W-1:0]   count;
    logic [DEPTH-1:0]   valid;
    logic [26:0]        tag_q  [DEPTH];
    logic [255:0]       data_q [DEPTH];
    logic [31:0]        fetch_addr;
    logic               hit;
    logic               full;
    logic               do_coalesce;
    logic               do_enqueue;
    logic               do_pop;

    // Low address bits only select a byte inside the line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[4:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Tag match over live entries; coalescing keeps at most one hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tag_q[i] == mem_address[31:5])) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign full        = (count == FULL_CNT);
    assign do_coalesce = (state == IDLE) && mem_write && hit;
    assign do_enqueue  = (state == IDLE) && mem_write && !hit && !full;
    assign do_pop      = (state == DRAIN) && pmem_resp;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; writes take priority over reads, requests over drain.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    state_next = (hit || !full) ? RESP : DRAIN;
                end else if (mem_read) begin
                    state_next = hit ? RESP : FETCH;
                end else if (count != '0) begin
                    state_next = DRAIN;
                end
            end
            FETCH:   if (pmem_resp) state_next = RESP;
            DRAIN:   if (pmem_resp) state_next = IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and registered storage only.
    always_comb begin
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            RESP:  mem_resp = 1'b1;
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = fetch_addr;
            end
            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[head], 5'b0};
                pmem_wdata   = data_q[head];
            end
            default: ;
        endcase
        buf_empty = (count == '0);
    end

    // FIFO control and returned-line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            valid     <= '0;
            mem_rdata <= '0;
        end else begin
            if (do_enqueue) begin
                valid[tail] <= 1'b1;
                tail        <= ptr_inc(tail);
                count       <= count + CNT_W'(1);
            end
            if (do_pop) begin
                valid[head] <= 1'b0;
                head        <= ptr_inc(head);
                count       <= count - CNT_W'(1);
            end
            if ((state == IDLE) && !mem_write && mem_read && hit) begin
                mem_rdata <= data_q[hit_idx];
            end
            if ((state == FETCH) && pmem_resp) begin
                mem_rdata <= pmem_rdata;
            end
        end
    end

    // Entry storage; liveness is tracked by valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_coalesce) begin
            data_q[hit_idx] <= mem_wdata;
        end
        if (do_enqueue) begin
            tag_q[tail]  <= mem_address[31:5];
            data_q[tail] <= mem_wdata;
        end
        if ((state == IDLE) && !mem_write && mem_read && !hit) begin
            fetch_addr <= {mem_address[31:5], 5'b0};
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer: basic write/drain, coalescing,
// read forwarding, read miss priority, full-buffer stall and reset mid-drain.
module tb_l2_write_buffer;

    logic         clk;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         buf_empty;

    l2_write_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .buf_empty    (buf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Adaptor model: answers pmem requests after a short latency when enabled.
    localparam int LAT = 2;
    logic mem_en = 1'b0;
    int   wait_cnt = 0;
    initial pmem_resp = 1'b0;
    always begin
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        if (mem_en && (pmem_read || pmem_write)) begin
            if (wait_cnt >= LAT) begin
                pmem_resp = 1'b1;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Transaction log of completed memory-side operations.
    logic [31:0]  wr_addr [64];
    logic [255:0] wr_data [64];
    int           n_wr = 0;
    int           rd_cycles = 0;
    logic [31:0]  rd_addr = '0;
    logic         both_seen = 1'b0;
    always @(posedge clk) begin
        if (pmem_read && pmem_write) both_seen = 1'b1;
        if (pmem_read) rd_cycles++;
        if (pmem_write && pmem_resp && n_wr < 64) begin
            wr_addr[n_wr] = pmem_address;
            wr_data[n_wr] = pmem_wdata;
            n_wr++;
        end
        if (pmem_read && pmem_resp) rd_addr = pmem_address;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s: timed out waiting, observed none expected event", tag);
    endtask

    task automatic wait_resp(input string tag, input int bound, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!mem_resp && lat < bound);
        if (!mem_resp) timeout(tag);
    endtask

    task automatic wait_empty(input string tag, input int bound);
        int k;
        k = 0;
        while (!buf_empty && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!buf_empty) timeout(tag);
    endtask

    logic [255:0] dA, dB, dC, dR, d0, d1, d2, d3, d4;
    int lat;
    int base;
    int k;
    logic saw;

    initial begin
        dA = {8{32'hA5A5_0001}};
        dB = {8{32'hB6B6_0002}};
        dC = {8{32'hC7C7_0003}};
        dR = {8{32'hDEAD_BEEF}};
        d0 = {8{32'h1000_0000}};
        d1 = {8{32'h1111_1111}};
        d2 = {8{32'h2222_2222}};
        d3 = {8{32'h3333_3333}};
        d4 = {8{32'h4444_4444}};
        pmem_rdata  = dR;
        rst         = 1'b1;
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_buf_empty", buf_empty, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic write then automatic drain
        mem_en = 1'b1;
        mem_address = 32'h0000_1040; mem_wdata = dA; mem_write = 1'b1;
        wait_resp("basic_resp", 50, lat);
        mem_write = 1'b0;
        chk("basic_lat", lat, 1);
        chk("basic_not_empty", buf_empty, 0);
        @(posedge clk); #1;
        chk("basic_resp_pulse", mem_resp, 0);
        wait_empty("basic_drain", 50);
        chk("basic_nwr", n_wr, 1);
        chk("basic_wr_addr", wr_addr[0], 32'h0000_1040);
        chk("basic_wr_data", wr_data[0], dA);

        // Coalesce with drain stalled
        mem_en = 1'b0;
        base = n_wr;
        mem_address = 32'h0000_2000; mem_wdata = dA; mem_write = 1'b1;
        wait_resp("coal_resp0", 50, lat);
        chk("coal_lat0", lat, 1);
        mem_address = 32'h0000_201C; mem_wdata = dB;
        wait_resp("coal_resp1", 50, lat);
        mem_write = 1'b0;
        chk("coal_lat1", lat, 2);
        chk("coal_count", dut.count, 1);
        mem_en = 1'b1;
        wait_empty("coal_drain", 50);
        repeat (10) @(posedge clk);
        #1;
        chk("coal_nwr", n_wr, base + 1);
        chk("coal_wr_addr", wr_addr[base], 32'h0000_2000);
        chk("coal_wr_data", wr_data[base], dB);

        // Read forward then read miss
        mem_en = 1'b0;
        base = n_wr;
        mem_address = 32'h0000_3000; mem_wdata = dC; mem_write = 1'b1;
        wait_resp("fwd_wresp", 50, lat);
        mem_write = 1'b0;
        mem_address = 32'h0000_3004; mem_read = 1'b1;
        wait_resp("fwd_rresp", 50, lat);
        chk("fwd_lat", lat, 2);
        chk("fwd_rdata", mem_rdata, dC);
        chk("fwd_no_pmem_read", rd_cycles, 0);
        mem_address = 32'h0000_4000;
        mem_en = 1'b1;
        wait_resp("miss_resp", 50, lat);
        mem_read = 1'b0;
        chk("miss_rdata", mem_rdata, dR);
        chk("miss_before_write", n_wr, base);
        chk("miss_addr", rd_addr, 32'h0000_4000);
        wait_empty("miss_drain", 50);
        chk("miss_wr_addr", wr_addr[base], 32'h0000_3000);
        chk("miss_wr_data", wr_data[base], dC);

        // Full buffer
        mem_en = 1'b0;
        base = n_wr;
        mem_write = 1'b1;
        mem_address = 32'h0000_5000; mem_wdata = d0;
        wait_resp("full_w0", 50, lat);
        mem_address = 32'h0000_5020; mem_wdata = d1;
        wait_resp("full_w1", 50, lat);
        mem_address = 32'h0000_5040; mem_wdata = d2;
        wait_resp("full_w2", 50, lat);
        mem_address = 32'h0000_5060; mem_wdata = d3;
        wait_resp("full_w3", 50, lat);
        mem_address = 32'h0000_5080; mem_wdata = d4;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mem_resp) saw = 1'b1;
        end
        chk("full_stall_no_resp", saw, 0);
        chk("full_stall_pwrite", pmem_write, 1);
        chk("full_stall_paddr", pmem_address, 32'h0000_5000);
        chk("full_stall_pwdata", pmem_wdata, d0);
        chk("full_stall_count", dut.count, 4);
        mem_en = 1'b1;
        wait_resp("full_w4", 50, lat);
        mem_write = 1'b0;
        chk("full_one_drain", n_wr, base + 1);
        chk("full_first_addr", wr_addr[base], 32'h0000_5000);
        chk("full_first_data", wr_data[base], d0);
        chk("full_count_after", dut.count, 4);
        k = 0;
        while (n_wr < base + 2 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        mem_en = 1'b0;
        if (n_wr < base + 2) timeout("full_second_drain");
        chk("full_second_addr", wr_addr[base + 1], 32'h0000_5020);
        k = 0;
        while (!pmem_write && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!pmem_write) timeout("rst_mid_wait_drain");
        chk("rst_mid_count", dut.count, 3);
        chk("rst_mid_head", pmem_address, 32'h0000_5040);

        // Reset mid-drain
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_pwrite", pmem_write, 0);
        chk("rst_mid_empty", buf_empty, 1);
        chk("rst_mid_paddr", pmem_address, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;
        base = n_wr;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (pmem_write) saw = 1'b1;
        end
        chk("rst_mid_no_writes", saw, 0);
        chk("rst_mid_nwr", n_wr, base);
        chk("never_rd_and_wr", both_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
